// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller slice.
//   exc_state_t : controller FSM states (encoding is visible through the MRS state read)
//   ESR_*       : exception syndrome codes
//   SYSREG_*    : MRS select encodings for sysreg_sel_i
package exc_pkg;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_TAKE    = 3'd1,
      ST_HANDLER = 3'd2,
      ST_RETURN  = 3'd3,
      ST_LOCKUP  = 3'd4
   } exc_state_t;

   localparam int ESR_UNDEF   = 1;
   localparam int ESR_IRQ     = 2;
   localparam int ESR_BADERET = 3;
   localparam int ESR_NESTED  = 4;

   localparam logic [1:0] SYSREG_ELR   = 2'b00;
   localparam logic [1:0] SYSREG_ESR   = 2'b01;
   localparam logic [1:0] SYSREG_STATE = 2'b10;
   localparam logic [1:0] SYSREG_ZERO  = 2'b11;

endpackage

// File: rtl/exc_sysregs.sv
// ELR/ESR holding registers and the MRS read mux.
//   clk, reset         : clock, synchronous active-high reset (clears ELR/ESR)
//   elr_we, elr_d      : ELR load enable / data
//   esr_we, esr_d      : ESR load enable / data
//   state_code         : current controller state, readable through MRS
//   sel                : MRS select (ELR, ESR, state, zero)
//   elr, esr           : current register contents
//   rdata              : combinational MRS read data, narrow fields zero-extended
module exc_sysregs
   import exc_pkg::*;
#(
   parameter int N     = 64,
   parameter int ESR_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             elr_we,
   input  logic [N-1:0]     elr_d,
   input  logic             esr_we,
   input  logic [ESR_W-1:0] esr_d,
   input  logic [2:0]       state_code,
   input  logic [1:0]       sel,
   output logic [N-1:0]     elr,
   output logic [ESR_W-1:0] esr,
   output logic [N-1:0]     rdata
);

   always_ff @(posedge clk) begin
      if (reset) begin
         elr <= '0;
         esr <= '0;
      end else begin
         if (elr_we) elr <= elr_d;
         if (esr_we) esr <= esr_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (sel)
         SYSREG_ELR:   rdata = elr;
         SYSREG_ESR:   rdata = {{(N-ESR_W){1'b0}}, esr};
         SYSREG_STATE: rdata = {{(N-3){1'b0}}, state_code};
         SYSREG_ZERO:  rdata = '0;
         default:      rdata = '0;
      endcase
   end

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt controller downstream of maindec.
// Squashes the offending decode instruction, captures ELR/ESR, redirects fetch to
// the handler vector (and back to ELR on ERET), pulses ExcAck for IRQ entries and
// serves MRS reads of ELR/ESR/state.
//   clk, reset      : clock, synchronous active-high reset
//   instr_valid_i   : decode-stage instruction valid
//   pc_i            : decode-stage PC
//   not_an_instr_i  : maindec NotAnInstr
//   eret_i          : maindec ERet
//   ext_irq_i       : level interrupt request, held until acked
//   sysreg_sel_i    : MRS select
//   squash_o        : comb kill of the decode instruction's writes
//   redirect_o      : registered next-PC override
//   redirect_pc_o   : redirect target (0 when not redirecting)
//   exc_ack_o       : registered one-cycle ack for IRQ entries
//   in_handler_o    : state is HANDLER
//   fatal_o         : state is LOCKUP
//   elr_o, esr_o    : current ELR / ESR
//   sysreg_rdata_o  : MRS read data
module exception_ctrl
   import exc_pkg::*;
#(
   parameter int             N      = 64,
   parameter logic [N-1:0]   VECTOR = 'hD8,
   parameter int             ESR_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid_i,
   input  logic [N-1:0]     pc_i,
   input  logic             not_an_instr_i,
   input  logic             eret_i,
   input  logic             ext_irq_i,
   input  logic [1:0]       sysreg_sel_i,
   output logic             squash_o,
   output logic             redirect_o,
   output logic [N-1:0]     redirect_pc_o,
   output logic             exc_ack_o,
   output logic             in_handler_o,
   output logic             fatal_o,
   output logic [N-1:0]     elr_o,
   output logic [ESR_W-1:0] esr_o,
   output logic [N-1:0]     sysreg_rdata_o
);

   exc_state_t       state;
   logic             in_run, in_hdl;
   logic             run_eret, run_undef, run_irq, take;
   logic             hdl_eret, hdl_undef;
   logic [ESR_W-1:0] take_esr;
   logic             elr_we, esr_we;
   logic [N-1:0]     elr_d;
   logic [ESR_W-1:0] esr_d;

   // Event decode. ERET outranks NotAnInstr because maindec raises both for ERET;
   // an IRQ only wins in RUN when no valid instruction event is present.
   always_comb begin
      in_run    = (state == ST_RUN);
      in_hdl    = (state == ST_HANDLER);
      run_eret  = in_run & instr_valid_i & eret_i;
      run_undef = in_run & instr_valid_i & not_an_instr_i & ~eret_i;
      run_irq   = in_run & ext_irq_i & ~(instr_valid_i & (eret_i | not_an_instr_i));
      take      = run_eret | run_undef | run_irq;
      hdl_eret  = in_hdl & instr_valid_i & eret_i;
      hdl_undef = in_hdl & instr_valid_i & not_an_instr_i & ~eret_i;

      take_esr = ESR_W'(ESR_IRQ);
      if (run_eret)       take_esr = ESR_W'(ESR_BADERET);
      else if (run_undef) take_esr = ESR_W'(ESR_UNDEF);

      // An IRQ arriving on a bubble is attributed to the preceding instruction slot.
      elr_d  = (run_irq & ~instr_valid_i) ? pc_i - N'(4) : pc_i;
      elr_we = take;
      esr_we = take | hdl_undef;
      esr_d  = take ? take_esr : ESR_W'(ESR_NESTED);

      squash_o = ~reset & (take | hdl_eret);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_RUN;
         redirect_o    <= 1'b0;
         redirect_pc_o <= '0;
         exc_ack_o     <= 1'b0;
      end else begin
         redirect_o    <= 1'b0;
         redirect_pc_o <= '0;
         exc_ack_o     <= 1'b0;
         case (state)
            ST_RUN: begin
               if (take) begin
                  state         <= ST_TAKE;
                  redirect_o    <= 1'b1;
                  redirect_pc_o <= VECTOR;
                  exc_ack_o     <= run_irq;
               end
            end
            ST_TAKE:    state <= ST_HANDLER;
            ST_HANDLER: begin
               if (hdl_eret) begin
                  state         <= ST_RETURN;
                  redirect_o    <= 1'b1;
                  redirect_pc_o <= elr_o;
               end else if (hdl_undef) begin
                  state <= ST_LOCKUP;
               end
            end
            ST_RETURN:  state <= ST_RUN;
            ST_LOCKUP:  state <= ST_LOCKUP;
            default:    state <= ST_RUN;
         endcase
      end
   end

   assign in_handler_o = (state == ST_HANDLER);
   assign fatal_o      = (state == ST_LOCKUP);

   exc_sysregs #(.N(N), .ESR_W(ESR_W)) u_sysregs (
      .clk        (clk),
      .reset      (reset),
      .elr_we     (elr_we),
      .elr_d      (elr_d),
      .esr_we     (esr_we),
      .esr_d      (esr_d),
      .state_code (state),
      .sel        (sysreg_sel_i),
      .elr        (elr_o),
      .esr        (esr_o),
      .rdata      (sysreg_rdata_o)
   );

endmodule
